// File: rtl/uart_loopback_display.sv
// UART receiver with a 2-digit hex readout on a multiplexed 4-digit 7-segment display.
// Define UART_LOOPBACK_EN to add a transmitter that echoes every received byte on UART_TX.
module uart_loopback_display #(
  parameter int CLKS_PER_BIT = 868,
  parameter int REFRESH_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_RX,
  output logic       UART_TX,
  output logic [3:0] IO_AN,
  output logic [7:0] IO_SEG,
  input  logic [4:0] IO_SW
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic unused_sw;
  assign unused_sw = ^IO_SW;

  logic rx_meta_q, rx_sync_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= UART_RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_dv_q, rx_dv_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, which rules out inferred latches.
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_byte_d  = rx_byte_q;
    rx_ferr_d  = rx_ferr_q;
    rx_dv_d    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d  = '0;
        rx_bit_d  = '0;
        rx_ferr_d = 1'b0;
        if (!rx_sync_q) rx_state_d = S_START;
      end
      S_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d  = '0;
          rx_byte_d = {rx_sync_q, rx_byte_q[7:1]};
          rx_bit_d  = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        // A low stop bit parks here until the line recovers, so a broken frame never re-triggers.
        if (rx_ferr_q) begin
          if (rx_sync_q) rx_state_d = S_IDLE;
        end else if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            rx_dv_d    = 1'b1;
            rx_state_d = S_IDLE;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_byte_q  <= '0;
      rx_ferr_q  <= 1'b0;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_byte_q  <= rx_byte_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  logic [7:0]              disp_q, disp_d;
  logic [REFRESH_BITS-1:0] scan_q, scan_d;
  logic [1:0]              digit;
  logic [3:0]              nibble;

  always_comb begin
    disp_d = rx_dv_q ? rx_byte_q : disp_q;
    scan_d = scan_q + REFRESH_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_q <= 8'h00;
      scan_q <= '0;
    end else begin
      disp_q <= disp_d;
      scan_q <= scan_d;
    end
  end

  assign digit = scan_q[REFRESH_BITS-1 -: 2];
  assign IO_AN = ~(4'b0001 << digit);

  always_comb begin
    case (digit)
      2'd0:    nibble = disp_q[3:0];
      2'd1:    nibble = disp_q[7:4];
      default: nibble = 4'h0;
    endcase
    case (nibble)
      4'h0: IO_SEG = 8'hC0;
      4'h1: IO_SEG = 8'hF9;
      4'h2: IO_SEG = 8'hA4;
      4'h3: IO_SEG = 8'hB0;
      4'h4: IO_SEG = 8'h99;
      4'h5: IO_SEG = 8'h92;
      4'h6: IO_SEG = 8'h82;
      4'h7: IO_SEG = 8'hF8;
      4'h8: IO_SEG = 8'h80;
      4'h9: IO_SEG = 8'h90;
      4'hA: IO_SEG = 8'h88;
      4'hB: IO_SEG = 8'h83;
      4'hC: IO_SEG = 8'hC6;
      4'hD: IO_SEG = 8'hA1;
      4'hE: IO_SEG = 8'h86;
      default: IO_SEG = 8'h8E;
    endcase
  end

`ifdef UART_LOOPBACK_EN
  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_accept;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = 1'b1;
    tx_accept  = 1'b0;
    case (tx_state_q)
      S_IDLE: tx_accept = rx_dv_q;
      S_START: begin
        tx_line_d = 1'b0;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = S_DATA;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        tx_line_d = tx_shift_q[0];
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = S_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        // The last stop cycle may accept a new byte so echoed frames can run back to back.
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = S_IDLE;
          tx_accept  = rx_dv_q;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_accept) begin
      tx_state_d = S_START;
      tx_cnt_d   = '0;
      tx_shift_d = rx_byte_q;
      tx_line_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  assign UART_TX = tx_line_q;
`else
  assign UART_TX = 1'b1;
`endif

endmodule

// File: tb/tb_uart_loopback_display.sv
// Scoreboard bench for uart_loopback_display: sent bytes are queued as expectations, and a
// negedge monitor checks rx_dv/byte, the display scan and the UART_TX waveform every cycle.
module tb_uart_loopback_display;
  localparam int CPB = 16;
  localparam int RB  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic [3:0] io_an;
  logic [7:0] io_seg;
  logic [4:0] io_sw = 5'b0;

  always #5 clk = ~clk;

  uart_loopback_display #(.CLKS_PER_BIT(CPB), .REFRESH_BITS(RB)) dut (
    .clk    (clk),
    .rst    (rst),
    .UART_RX(uart_rx),
    .UART_TX(uart_tx),
    .IO_AN  (io_an),
    .IO_SEG (io_seg),
    .IO_SW  (io_sw)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] table_q [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return table_q[n];
  endfunction

  logic [7:0] exp_rx_q[$];
  logic       tx_line_q[$];

  logic       rst_prev = 1'b0;
  bit         armed = 1'b0;
  int         scan_m = 0;
  int         digit;
  logic [7:0] disp_m = 8'h00;
  logic [3:0] nib, exp_an;
  logic       exp_tx;
  logic [7:0] e;

  // Model: display shows the last good byte; an echo frame is 10 bit-times starting the
  // cycle after rx_dv, accepted only when no earlier echo frame is still pending.
  always @(negedge clk) begin
    if (rst_prev) begin
      armed  = 1'b1;
      scan_m = 0;
      disp_m = 8'h00;
      tx_line_q.delete();
    end else begin
      scan_m = (scan_m + 1) % (1 << RB);
    end
    if (armed) begin
      digit  = scan_m >> (RB - 2);
      exp_an = ~(4'b0001 << digit);
      nib    = (digit == 0) ? disp_m[3:0] : (digit == 1) ? disp_m[7:4] : 4'h0;
      check("io_an", io_an, exp_an);
      check("io_seg", io_seg, glyph(nib));
      exp_tx = (tx_line_q.size() > 0) ? tx_line_q.pop_front() : 1'b1;
      check("uart_tx", uart_tx, exp_tx);
      if (dut.rx_dv_q) begin
        if (exp_rx_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_dv: unexpected pulse with byte 0x%0h, no byte expected at %0t",
                   dut.rx_byte_q, $time);
        end else begin
          e = exp_rx_q.pop_front();
          check("rx_byte", dut.rx_byte_q, e);
          disp_m = e;
`ifdef UART_LOOPBACK_EN
          if (tx_line_q.size() == 0) begin
            for (int k = 0; k < CPB; k++) tx_line_q.push_back(1'b0);
            for (int b = 0; b < 8; b++)
              for (int k = 0; k < CPB; k++) tx_line_q.push_back(e[b]);
            for (int k = 0; k < CPB; k++) tx_line_q.push_back(1'b1);
          end
`endif
        end
      end
    end
    rst_prev = rst;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic stop_bit);
    if (stop_bit) exp_rx_q.push_back(b);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB);
    uart_rx = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    uart_rx = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(40);

    send(8'hA5, 1'b1);
    tick(20);

    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(40);

    send(8'h3C, 1'b0);
    tick(30);
    send(8'h7E, 1'b1);
    tick(170);

    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    tick(200);

    for (int i = 0; i < 8; i++) begin
      send(8'($urandom_range(0, 255)), 1'b1);
      tick($urandom_range(0, 40));
    end
    tick(180);

    // Abort a frame mid-byte: start bit plus three data bits, then reset.
    uart_rx = 1'b0;
    tick(CPB);
    uart_rx = 1'b1;
    tick(CPB);
    uart_rx = 1'b0;
    tick(2 * CPB);
    rst = 1'b1;
    uart_rx = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(40);

    send(8'h96, 1'b1);
    tick(60);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(50);

    send(8'h5A, 1'b1);
    send(8'hC3, 1'b1);

    for (int i = 0; i < 600 && (exp_rx_q.size() != 0 || tx_line_q.size() != 0); i++) tick(1);
    check("rx_queue_drained", exp_rx_q.size(), 0);
    check("tx_queue_drained", tx_line_q.size(), 0);
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
